// File: rtl/key_debounce.sv
// Push-button conditioner: 2-FF synchroniser, bounce-rejecting FSM, registered press/release strobes.
// Define KEY_LONG_PRESS_EN to add a one-shot key_long strobe after LONG_PRESS_MS of holding.
module key_debounce #(
  parameter int CLK_FREQ_HZ    = 50_000_000,
  parameter int DEBOUNCE_MS    = 20,
  parameter int KEY_ACTIVE_LOW = 1,
  parameter int LONG_PRESS_MS  = 1000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int DEB_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int CNT_W      = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic RELEASED = (KEY_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               level_q, level_d;
  logic               press_q, press_d;
  logic               release_q, release_d;
  logic               key_sync;

  // XOR with the released level turns the synchronised pin into 1 = pressed.
  assign key_sync = sync2_q ^ RELEASED;

  always_comb begin
    sync1_d   = key_in;
    sync2_d   = sync1_q;
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (key_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!key_sync) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PRESSED: begin
        if (!key_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (key_sync) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sync1_q   <= RELEASED;
      sync2_q   <= RELEASED;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;

`ifdef KEY_LONG_PRESS_EN
  localparam int LONG_CYCLES = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int LCNT_W      = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LCNT_W-1:0] LCNT_LAST = LCNT_W'(LONG_CYCLES - 1);

  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              long_done_q, long_done_d;
  logic              long_q, long_d;

  // lcnt saturates at its last value; long_done blocks a second strobe in the same press.
  always_comb begin
    lcnt_d      = lcnt_q;
    long_done_d = long_done_q;
    long_d      = 1'b0;
    if (state_q == PRESSED) begin
      if (lcnt_q == LCNT_LAST) begin
        if (!long_done_q) begin
          long_d      = 1'b1;
          long_done_d = 1'b1;
        end
      end else begin
        lcnt_d = lcnt_q + 1'b1;
      end
    end
    if ((state_q == PRESS_WAIT && state_d == PRESSED) ||
        (state_q != IDLE && state_d == IDLE)) begin
      lcnt_d      = '0;
      long_done_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
      long_q      <= 1'b0;
    end else begin
      lcnt_q      <= lcnt_d;
      long_done_q <= long_done_d;
      long_q      <= long_d;
    end
  end

  assign key_long = long_q;
`else
  // LONG_PRESS_MS has no effect in this build; the term folds to a constant 0.
  assign key_long = 1'b0 & (LONG_PRESS_MS < 0);
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random bounce, checked against a
// run-length reference model of the debouncer (key_long expectations follow KEY_LONG_PRESS_EN).
module tb_key_debounce;

  localparam int DEB  = 10;
  localparam int LONG = 50;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  logic key_in  = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int checks = 0;
  int errors = 0;

  // Reference model state: pressed-ness samples in flight, accepted level, disagreement run.
  bit m_hist[$];
  bit m_level;
  int m_run;
  int m_lc;
  bit m_fired;
  bit e_press, e_release, e_long;

  wire [3:0] dut_vec = {key_level, key_press, key_release, key_long};
  wire [3:0] exp_vec = {m_level, e_press, e_release, e_long};

  key_debounce #(
    .CLK_FREQ_HZ   (10_000),
    .DEBOUNCE_MS   (1),
    .KEY_ACTIVE_LOW(1),
    .LONG_PRESS_MS (5)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #50 sys_clk = ~sys_clk;

  task automatic model_reset();
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
    m_level   = 1'b0;
    m_run     = 0;
    m_lc      = 0;
    m_fired   = 1'b0;
    e_press   = 1'b0;
    e_release = 1'b0;
    e_long    = 1'b0;
  endtask

  // A change is accepted once the key has disagreed with the accepted level for
  // DEB+1 consecutive samples, two clocks after the pin was sampled.
  task automatic model_edge();
    bit seen;
    bit long_hit;
    long_hit  = 1'b0;
    seen      = m_hist.pop_front();
    m_hist.push_back(~key_in);
    e_press   = 1'b0;
    e_release = 1'b0;
    if (m_level && m_run == 0) begin
      if (m_lc == LONG - 1) begin
        if (!m_fired) begin
          long_hit = 1'b1;
          m_fired  = 1'b1;
        end
      end else begin
        m_lc++;
      end
    end
    if (seen != m_level) begin
      m_run++;
      if (m_run == DEB + 1) begin
        m_level = seen;
        m_run   = 0;
        m_lc    = 0;
        m_fired = 1'b0;
        if (seen) e_press = 1'b1;
        else      e_release = 1'b1;
      end
    end else begin
      m_run = 0;
    end
`ifdef KEY_LONG_PRESS_EN
    e_long = long_hit;
`else
    e_long = 1'b0;
`endif
  endtask

  task automatic step(input logic v);
    key_in = v;
    @(posedge sys_clk);
    if (!sys_rst) model_edge();
    #1;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    key_in  = 1'b1;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (dut_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: outputs got %b expected 0000", dut_vec);
    end
    sys_rst = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      step(1'b1);
      checks++;
      if (dut_vec !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: outputs got %b expected 0000", i, dut_vec);
      end
    end
    $display("test_reset done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_press_latency();
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      checks++;
      if (key_press !== (i == 13)) begin
        errors++;
        $display("FAIL press_latency edge %0d: key_press got %b expected %b", i, key_press, (i == 13));
      end
      checks++;
      if (key_level !== (i >= 13)) begin
        errors++;
        $display("FAIL press_level edge %0d: key_level got %b expected %b", i, key_level, (i >= 13));
      end
    end
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      checks++;
      if (key_release !== (i == 13) || key_level !== (i < 13)) begin
        errors++;
        $display("FAIL release_latency edge %0d: release/level got %b%b expected %b%b",
                 i, key_release, key_level, (i == 13), (i < 13));
      end
    end
    $display("test_press_latency done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_bounce();
    int strobes;
    strobes = 0;
    for (int i = 0; i < 60; i++) begin
      step((i >= 40) ? 1'b1 : (((i / 4) % 2) == 0 ? 1'b0 : 1'b1));
      if (key_press || key_release) strobes++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL bounce cycle %0d: outputs got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    checks++;
    if (strobes != 0 || key_level !== 1'b0) begin
      errors++;
      $display("FAIL bounce_result: strobes=%0d level=%b expected strobes=0 level=0", strobes, key_level);
    end
    $display("test_bounce done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_release_glitch();
    int releases;
    releases = 0;
    for (int i = 0; i < 38; i++) begin
      step((i < 30) ? 1'b0 : ((i < 35) ? 1'b1 : 1'b0));
      if (key_release) releases++;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL glitch_phase cycle %0d: outputs got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      if (key_release) releases++;
      checks++;
      if (key_release !== (i == 13) || key_level !== (i < 13)) begin
        errors++;
        $display("FAIL glitch_release edge %0d: release/level got %b%b expected %b%b",
                 i, key_release, key_level, (i == 13), (i < 13));
      end
    end
    checks++;
    if (releases != 1) begin
      errors++;
      $display("FAIL glitch_release_count: got %0d expected 1", releases);
    end
    $display("test_release_glitch done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_reset_midpress();
    // Abort inside PRESS_WAIT with the counter part-way.
    for (int i = 1; i <= 8; i++) step(1'b0);
    #20;
    sys_rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_wait: outputs got %b expected 0000", dut_vec);
    end
    step(1'b0);
    step(1'b0);
    sys_rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0);
      checks++;
      if (key_press !== (i == 13) || key_level !== (i >= 13)) begin
        errors++;
        $display("FAIL post_reset_press edge %0d: press/level got %b%b expected %b%b",
                 i, key_press, key_level, (i == 13), (i >= 13));
      end
    end
    // Abort while pressed: level drops at once and no release strobe follows.
    #20;
    sys_rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_pressed: outputs got %b expected 0000", dut_vec);
    end
    step(1'b1);
    sys_rst = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL post_reset_idle cycle %0d: outputs got %b expected %b", i, dut_vec, exp_vec);
      end
    end
    $display("test_reset_midpress done: checks=%0d errors=%0d", checks, errors);
  endtask

  task automatic test_long_press();
    int p_edge;
    int l_edge;
    int n_long;
    p_edge = -1;
    l_edge = -1;
    n_long = 0;
    for (int i = 1; i <= 100; i++) begin
      step((i <= 80) ? 1'b0 : 1'b1);
      if (key_press) p_edge = i;
      if (key_long) begin
        n_long++;
        l_edge = i;
      end
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL long_cycle %0d: outputs got %b expected %b", i, dut_vec, exp_vec);
      end
    end
`ifdef KEY_LONG_PRESS_EN
    checks++;
    if (n_long != 1 || (l_edge - p_edge) != LONG) begin
      errors++;
      $display("FAIL long_press: count=%0d delay=%0d expected count=1 delay=%0d",
               n_long, l_edge - p_edge, LONG);
    end
`else
    checks++;
    if (n_long != 0) begin
      errors++;
      $display("FAIL long_disabled: key_long pulses=%0d expected 0", n_long);
    end
`endif
    $display("test_long_press done: press_edge=%0d long_edge=%0d checks=%0d errors=%0d",
             p_edge, l_edge, checks, errors);
  endtask

  task automatic test_random();
    int  cyc;
    bit  last_was_press;
    logic v;
    int  len;
    cyc = 0;
    last_was_press = 1'b0;
    while (cyc < 1500) begin
      v   = logic'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      for (int k = 0; k < len; k++) begin
        step(v);
        cyc++;
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL random cycle %0d: outputs got %b expected %b", cyc, dut_vec, exp_vec);
        end
        if (key_press) begin
          checks++;
          if (last_was_press || key_release) begin
            errors++;
            $display("FAIL strobe_order cycle %0d: press seen with prior_press=%b release=%b expected 0 0",
                     cyc, last_was_press, key_release);
          end
          last_was_press = 1'b1;
        end
        if (key_release) last_was_press = 1'b0;
      end
    end
    $display("test_random done: cycles=%0d checks=%0d errors=%0d", cyc, checks, errors);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_latency();
    test_bounce();
    test_release_glitch();
    test_reset_midpress();
    for (int i = 0; i < 25; i++) step(1'b1);
    test_long_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
